// File: rtl/instr_prefetch_pkg.sv
// rtl/instr_prefetch_pkg.sv - shared defaults and fetch FSM encoding for the prefetch front-end
package instr_prefetch_pkg;

  localparam int DEFAULT_WORD_WIDTH = 16;
  localparam int DEFAULT_DEPTH      = 4;

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,
    FETCH_REQ     = 2'd1,
    FETCH_DISCARD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - registered sync FIFO of {instr, pc} pairs with flush, no bypass
module instr_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     do_reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Flush wins over a same-cycle push or pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!do_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign head  = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_prefetch.sv
// rtl/instr_prefetch.sv - sequential instruction fetch with redirect flush feeding a decoder queue
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int                    WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int                    DEPTH      = DEFAULT_DEPTH,
  parameter logic [WORD_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  do_reset_n,
  output logic                  mem_req,
  output logic [WORD_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [WORD_WIDTH-1:0] mem_data,
  input  logic                  redirect,
  input  logic [WORD_WIDTH-1:0] redirect_addr,
  output logic [WORD_WIDTH-1:0] instr,
  output logic [WORD_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e          state_q, state_d;
  logic [WORD_WIDTH-1:0] fp_q, fp_d;

  logic                    push;
  logic                    pop;
  logic [CW-1:0]           q_count;
  logic [CW-1:0]           count_next;
  logic                    q_full;
  logic                    q_empty;
  logic [2*WORD_WIDTH-1:0] q_head;

  assign push        = (state_q == FETCH_REQ) && mem_ack && !redirect;
  assign pop         = instr_valid && instr_ready;
  assign count_next  = q_count + CW'(push) - CW'(pop);

  always_comb begin
    state_d = state_q;
    fp_d    = fp_q;
    case (state_q)
      FETCH_IDLE: begin
        if (redirect) begin
          fp_d    = redirect_addr;
          state_d = FETCH_REQ;
        end else if (!q_full || pop) begin
          state_d = FETCH_REQ;
        end
      end
      FETCH_REQ: begin
        if (redirect) begin
          fp_d    = redirect_addr;
          state_d = mem_ack ? FETCH_REQ : FETCH_DISCARD;
        end else if (mem_ack) begin
          fp_d    = fp_q + WORD_WIDTH'(1);
          state_d = (count_next < CW'(DEPTH)) ? FETCH_REQ : FETCH_IDLE;
        end
      end
      FETCH_DISCARD: begin
        // The stale read must complete before a request for the new target can start.
        if (redirect) begin
          fp_d = redirect_addr;
        end
        if (mem_ack) begin
          state_d = FETCH_REQ;
        end
      end
      default: begin
        state_d = FETCH_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!do_reset_n) begin
      state_q <= FETCH_IDLE;
      fp_q    <= RESET_ADDR;
    end else begin
      state_q <= state_d;
      fp_q    <= fp_d;
    end
  end

  instr_queue #(
    .WIDTH (2*WORD_WIDTH),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .do_reset_n (do_reset_n),
    .push       (push),
    .pop        (pop),
    .flush      (redirect),
    .wdata      ({mem_data, fp_q}),
    .head       (q_head),
    .count      (q_count),
    .full       (q_full),
    .empty      (q_empty)
  );

  assign mem_req     = (state_q != FETCH_IDLE);
  assign mem_addr    = fp_q;
  assign instr_valid = !q_empty;
  assign instr       = q_head[2*WORD_WIDTH-1:WORD_WIDTH];
  assign instr_pc    = q_head[WORD_WIDTH-1:0];

endmodule
